// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// fetch_stage : IF stage - PC, req/gnt/rvalid imem handshake, IF/ID register.
// Optional counters under FETCH_PERF_CNT_EN.            Revision: 1.0
// ============================================================================
module fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [31:0]       id_instr
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [15:0]       flush_count
`endif
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              req_q, req_d;
    logic [31:0]       hold_q, hold_d;
    logic              id_valid_q, id_valid_d;
    logic [ADDR_W-1:0] id_pc_q, id_pc_d;
    logic [31:0]       id_instr_q, id_instr_d;

    logic              w_accept;
    logic              w_deliver;
    logic              w_capture;
    logic              w_hold_exit;
    logic [31:0]       w_instr;
    logic [ADDR_W-1:0] w_pc_inc;

    // req_q is low for the first cycle after reset, so no grant is honoured then
    assign w_accept  = req_q & imem_gnt;
    assign w_pc_inc  = pc_q + ADDR_W'(4);
    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign id_valid  = id_valid_q;
    assign id_pc     = id_pc_q;
    assign id_instr  = id_instr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ: begin
                if (w_accept) begin
                    state_d = branch_taken ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_d = (branch_taken || !freeze) ? S_REQ : S_HOLD;
                end else if (branch_taken) begin
                    state_d = S_DROP;
                end
            end
            S_HOLD: begin
                if (branch_taken || !freeze) begin
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_comb begin
        w_hold_exit = (state_q == S_HOLD) && (branch_taken || !freeze);
        w_capture   = (state_q == S_WAIT) && imem_rvalid && freeze && !branch_taken;
        w_deliver   = !branch_taken && !freeze &&
                      (((state_q == S_WAIT) && imem_rvalid) || (state_q == S_HOLD));
        w_instr     = (state_q == S_HOLD) ? hold_q : imem_rdata;
        req_d       = (state_d == S_REQ);

        pc_d = pc_q;
        if (branch_taken) begin
            pc_d = branch_addr;
        end else if (w_deliver) begin
            pc_d = w_pc_inc;
        end

        hold_d = hold_q;
        if (w_capture) begin
            hold_d = imem_rdata;
        end else if (w_hold_exit) begin
            hold_d = '0;
        end

        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_instr_d = id_instr_q;
        if (branch_taken) begin
            id_valid_d = 1'b0;
            id_pc_d    = '0;
            id_instr_d = '0;
        end else if (freeze) begin
            id_valid_d = id_valid_q;
        end else if (w_deliver) begin
            id_valid_d = 1'b1;
            id_pc_d    = w_pc_inc;
            id_instr_d = w_instr;
        end else begin
            id_valid_d = 1'b0;
            id_instr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            req_q      <= 1'b0;
            hold_q     <= '0;
            id_valid_q <= 1'b0;
            id_pc_q    <= '0;
            id_instr_q <= '0;
        end else begin
            pc_q       <= pc_d;
            req_q      <= req_d;
            hold_q     <= hold_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_instr_q <= id_instr_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_q;
    logic [15:0] flush_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (freeze && !branch_taken && (stall_q != '1)) begin
                stall_q <= stall_q + 32'd1;
            end
            if (branch_taken && (flush_q != '1)) begin
                flush_q <= flush_q + 16'd1;
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// tb_fetch_stage : scoreboard bench for fetch_stage with a 1-deep memory model.
// Revision: 1.0
// ============================================================================
module tb_fetch_stage;

    localparam int          ADDR_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    fetch_stage #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .id_valid     (id_valid),
        .id_pc        (id_pc),
        .id_instr     (id_instr)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    int          n_cmp = 0;
    int          n_err = 0;
    bit          pending, p_live, held, first;
    logic [31:0] exp_pc, h_data;
    int          stall_exp, flush_exp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return 32'hE3A0_0001 + a;
    endfunction

    task automatic clear_model();
        pending   = 1'b0;
        p_live    = 1'b0;
        held      = 1'b0;
        first     = 1'b1;
        exp_pc    = RESET_PC;
        h_data    = '0;
        cur       = '{1'b0, 32'h0, 32'h0};
        stall_exp = 0;
        flush_exp = 0;
        sb.delete();
    endtask

    // One clock: drive inputs, predict IF/ID and PC, then compare after the edge.
    task automatic step(input bit br, input logic [31:0] ba, input bit frz,
                        input bit gen, input bit ren);
        bit          gnt, rv, dlv, busy;
        logic [31:0] d;
        exp_t        e;
        busy = pending || held;
        gnt  = gen && !busy && !first;
        rv   = pending && ren;
        d    = rv ? mem_data(exp_pc) : $urandom;
        freeze       = frz;
        branch_taken = br;
        branch_addr  = ba;
        imem_gnt     = gnt;
        imem_rvalid  = rv;
        imem_rdata   = d;

        dlv = 1'b0;
        if (rv) begin
            pending = 1'b0;
            if (p_live && !br) begin
                if (!frz) dlv = 1'b1;
                else begin
                    held   = 1'b1;
                    h_data = d;
                end
            end
        end else if (held && !br && !frz) begin
            dlv  = 1'b1;
            d    = h_data;
            held = 1'b0;
        end
        if (br) begin
            held   = 1'b0;
            p_live = 1'b0;
            cur    = '{1'b0, 32'h0, 32'h0};
            exp_pc = ba;
        end else if (dlv) begin
            cur    = '{1'b1, exp_pc + 32'd4, d};
            exp_pc = exp_pc + 32'd4;
        end else if (!frz) begin
            cur.v     = 1'b0;
            cur.instr = '0;
        end
        if (gnt) begin
            pending = 1'b1;
            p_live  = !br;
        end
        if (frz && !br) stall_exp++;
        if (br) flush_exp++;
        sb.push_back(cur);

        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("id_valid", 32'(id_valid), 32'(e.v));
        check("id_pc", id_pc, e.pc);
        check("id_instr", id_instr, e.instr);
        check("imem_req", 32'(imem_req), 32'(!(pending || held)));
        if (!(pending || held)) check("imem_addr", imem_addr, exp_pc);
        first = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        check("rst_id_valid", 32'(id_valid), 32'h0);
        check("rst_id_pc", id_pc, 32'h0);
        check("rst_id_instr", id_instr, 32'h0);
        check("rst_imem_req", 32'(imem_req), 32'h0);
        check("rst_imem_addr", imem_addr, RESET_PC);
`ifdef FETCH_PERF_CNT_EN
        check("rst_stall", stall_cycles, 32'h0);
        check("rst_flush", 32'(flush_count), 32'h0);
`endif
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = '0;
        imem_gnt     = 1'b0;
        imem_rvalid  = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        clear_model();
        do_reset();
        // fetch 0 and 4, then PC 8 frozen for 3 cycles from its rvalid
        repeat (6) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        repeat (3) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        // branch while waiting, late data dropped
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 32'h100, 1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        // branch and freeze together in the rvalid cycle
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 32'h200, 1'b1, 1'b1, 1'b1);
        // redirect while ungranted
        step(1'b1, 32'h300, 1'b0, 1'b0, 1'b1);
        repeat (2) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        // grant with branch, then branch again as the dropped data returns
        step(1'b1, 32'h400, 1'b0, 1'b1, 1'b1);
        step(1'b1, 32'h500, 1'b0, 1'b1, 1'b1);
        repeat (2) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        // PC wrap
        step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1);
        repeat (4) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(9) == 0, $urandom, $urandom_range(3) == 0,
                 $urandom_range(3) != 0, $urandom_range(2) != 0);
        end
`ifdef FETCH_PERF_CNT_EN
        check("stall_cycles", stall_cycles, 32'(stall_exp));
        check("flush_count", 32'(flush_count), 32'(flush_exp));
`endif
        // reset in the middle of a wait at 0x40
        step(1'b1, 32'h40, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        do_reset();
        repeat (4) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
